// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the load/store path and the data-memory responder.
interface dmem_responder_if #(parameter int AW = 32);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: 3-cycle registered data-memory responder with byte/half/word access.
// Defining DMEM_ERR_CNT_EN adds a saturating err_count output.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW = 32
) (
   input logic clk,
   input logic rst,
   dmem_responder_if.slave bus
`ifdef DMEM_ERR_CNT_EN
   ,output logic [15:0] err_count
`endif
);
   localparam int IW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state_q, state_d;
   logic we_q, we_d, err_q, err_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [2:0] f3_q, f3_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d, rd_q, rd_d, rsp_rdata_q, rsp_rdata_d;
   logic [31:0] mem [DEPTH_WORDS];
   logic err, oob;
   logic [IW-1:0] widx;
   logic [3:0] be;
   logic [31:0] wlane, sh, ext;
   assign oob = (addr_q >> 2) >= AW'(DEPTH_WORDS);
   assign err = f3_q == 3'b011 || f3_q[2:1] == 2'b11 || (we_q && f3_q[2]) ||
                (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) || oob;
   assign widx = addr_q[IW+1:2];
   assign be = f3_q[1] ? 4'b1111 : f3_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
   assign wlane = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
   // Right-align the addressed lane(s) before extension; funct3[2] selects zero-extension.
   assign sh = rd_q >> {addr_q[1:0], 3'b000};
   assign ext = f3_q[1] ? rd_q : f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]}
                                         : {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
   always_comb begin
      state_d = state_q;
      we_d = we_q;
      f3_d = f3_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rd_d = rd_q;
      err_d = err_q;
      rsp_valid_d = state_q == RESP;
      rsp_err_d = state_q == RESP && err_q;
      rsp_rdata_d = (state_q == RESP && !err_q && !we_q) ? ext : '0;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            we_d = bus.req_we;
            f3_d = bus.req_funct3;
            addr_d = bus.req_addr;
            wdata_d = bus.req_wdata;
            state_d = ACCESS;
         end
         ACCESS: begin
            err_d = err;
            rd_d = (!err && !we_q) ? mem[widx] : '0;
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         we_q <= 1'b0;
         f3_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         rd_q <= '0;
         err_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q <= we_d;
         f3_q <= f3_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rd_q <= rd_d;
         err_q <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   // RAM is not reset; the write commits only on the ACCESS->RESP edge.
   always_ff @(posedge clk)
      if (state_q == ACCESS && !err && we_q)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
`ifdef DMEM_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   assign err_cnt_d = (state_q == ACCESS && err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) err_cnt_q <= '0;
      else err_cnt_q <= err_cnt_d;
   assign err_count = err_cnt_q;
`endif
   assign bus.req_ready = state_q == IDLE;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule
